// File: rtl/uart_loader_pkg.sv
// Shared types and default register map for the UART word loader.
package uart_loader_pkg;

  // Polling state machine: idle/gate, status poll, RX data read.
  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_CHECK = 2'd1,
    S_READ  = 2'd2
  } state_t;

  // Default byte offsets of the RS-232 UART core registers.
  localparam int DEF_RX_ADDR     = 0;
  localparam int DEF_STATUS_ADDR = 8;

  // Status register bit positions.
  localparam int RX_OK_POS = 7;
  localparam int TX_OK_POS = 6;

  // Index width that stays legal when only one slot exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_word_loader_fifo.sv
// First-word fall-through FIFO with flush; push and pop may coincide at any
// occupancy, including full.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero while empty so the output is clean after reset.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_word_loader.sv
// Avalon-MM master polling a UART core; packs received bytes MSB first into
// words and queues them for a valid/ready consumer, with framing and timeout.
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int BYTES_PER_WORD = 3,
  parameter int ADDR_W         = 5,
  parameter int RX_ADDR        = DEF_RX_ADDR,
  parameter int STATUS_ADDR    = DEF_STATUS_ADDR,
  parameter int RX_OK_BIT      = RX_OK_POS,
  parameter int FIFO_DEPTH     = 4,
  parameter int IDLE_TIMEOUT   = 1000000,
  parameter int FRAME_W        = 20
) (
  input  logic                        avm_clk,
  input  logic                        avm_rst_n,
  output logic [ADDR_W-1:0]           avm_address,
  output logic                        avm_read,
  input  logic [31:0]                 avm_readdata,
  input  logic                        avm_waitrequest,
  input  logic                        i_clear,
  input  logic [FRAME_W-1:0]          i_frame_words,
  output logic [8*BYTES_PER_WORD-1:0] o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [FRAME_W-1:0]          o_word_idx,
  output logic                        o_frame_done,
  output logic                        o_drop,
  output state_t                      dbg_state
);

  localparam int W      = 8 * BYTES_PER_WORD;
  localparam int BIDX_W = idx_width(BYTES_PER_WORD);
  localparam int TCNT_W = $clog2(IDLE_TIMEOUT + 1);

  // Handshake: a read transfer completes on the cycle avm_read && !avm_waitrequest;
  // address/read hold while stalled and read drops for a cycle after each
  // completion. Output side pops on o_valid && i_ready.

  state_t                  state;
  state_t                  state_nx;
  logic                    read_nx;
  logic [ADDR_W-1:0]       addr_nx;
  logic                    clr_pend;
  logic                    clr_pend_nx;
  logic                    accept;
  logic                    rx_accept;
  logic                    last_byte;
  logic                    push;
  logic                    frame_wrap;
  logic [BIDX_W-1:0]       byte_idx;
  logic [W-1:0]            word_r;
  logic [W-1:0]            push_word;
  logic [TCNT_W-1:0]       tcnt;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                    unused_bits;

  assign dbg_state  = state;
  assign accept     = avm_read && !avm_waitrequest;
  // A byte is kept only if no clear hit this transfer.
  assign rx_accept  = (state == S_READ) && accept && !i_clear && !clr_pend;
  assign last_byte  = (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));
  assign push       = rx_accept && last_byte;
  assign frame_wrap = (i_frame_words != '0) && (o_word_idx == i_frame_words - 1'b1);
  assign o_valid    = !fifo_empty;
  assign unused_bits = ^{avm_readdata, fifo_count};

  // Merge the incoming byte into its slot; slot 0 is the MSB.
  always_comb begin
    push_word = word_r;
    push_word[8*(BYTES_PER_WORD-1-int'(byte_idx)) +: 8] = avm_readdata[7:0];
  end

  // FSM state and registered Avalon command.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state       <= S_WAIT;
      avm_read    <= 1'b0;
      avm_address <= ADDR_W'(STATUS_ADDR);
      clr_pend    <= 1'b0;
    end else begin
      state       <= state_nx;
      avm_read    <= read_nx;
      avm_address <= addr_nx;
      clr_pend    <= clr_pend_nx;
    end
  end

  // Next-state and next-command logic.
  always_comb begin
    state_nx    = state;
    read_nx     = avm_read;
    addr_nx     = avm_address;
    clr_pend_nx = clr_pend;
    case (state)
      S_WAIT: begin
        read_nx = 1'b0;
        if (!fifo_full && !i_clear) begin
          state_nx = S_CHECK;
          read_nx  = 1'b1;
          addr_nx  = ADDR_W'(STATUS_ADDR);
        end
      end
      S_CHECK: begin
        if (avm_read) begin
          if (!avm_waitrequest) begin
            read_nx = 1'b0;
            if (i_clear || clr_pend) begin
              state_nx    = S_WAIT;
              clr_pend_nx = 1'b0;
            end else if (avm_readdata[RX_OK_BIT]) begin
              state_nx = S_READ;
            end else if (fifo_full) begin
              state_nx = S_WAIT;
            end
          end else if (i_clear) begin
            clr_pend_nx = 1'b1;
          end
        end else if (i_clear || fifo_full) begin
          state_nx = S_WAIT;
        end else begin
          read_nx = 1'b1;
          addr_nx = ADDR_W'(STATUS_ADDR);
        end
      end
      S_READ: begin
        if (avm_read) begin
          if (!avm_waitrequest) begin
            read_nx     = 1'b0;
            state_nx    = S_WAIT;
            clr_pend_nx = 1'b0;
          end else if (i_clear) begin
            clr_pend_nx = 1'b1;
          end
        end else if (i_clear) begin
          state_nx = S_WAIT;
        end else begin
          read_nx = 1'b1;
          addr_nx = ADDR_W'(RX_ADDR);
        end
      end
      default: begin
        state_nx = S_WAIT;
        read_nx  = 1'b0;
      end
    endcase
  end

  // Byte assembly, frame index, and partial-word timeout.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      byte_idx     <= '0;
      word_r       <= '0;
      tcnt         <= '0;
      o_word_idx   <= '0;
      o_frame_done <= 1'b0;
      o_drop       <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_drop       <= 1'b0;
      if (i_clear) begin
        byte_idx   <= '0;
        tcnt       <= '0;
        o_word_idx <= '0;
      end else if (rx_accept) begin
        word_r <= push_word;
        tcnt   <= '0;
        if (last_byte) begin
          byte_idx <= '0;
          if (frame_wrap) begin
            o_word_idx   <= '0;
            o_frame_done <= 1'b1;
          end else begin
            o_word_idx <= o_word_idx + 1'b1;
          end
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end else if (byte_idx == '0) begin
        tcnt <= '0;
      end else if (tcnt == TCNT_W'(IDLE_TIMEOUT - 1)) begin
        byte_idx <= '0;
        tcnt     <= '0;
        o_drop   <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (avm_clk),
    .rst_n (avm_rst_n),
    .flush (i_clear),
    .push  (push),
    .wdata (push_word),
    .pop   (o_valid && i_ready),
    .rdata (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: UART/Avalon slave model, byte-level reference
// model feeding an expected-word queue, and a monitor that checks outputs.
`timescale 1ns/1ps
module tb_uart_word_loader;
  import uart_loader_pkg::*;

  localparam int BPW = 3;
  localparam int ADDR_W = 5;
  localparam int RX_ADDR = 0;
  localparam int STATUS_ADDR = 8;
  localparam int RX_OK_BIT = 7;
  localparam int FIFO_DEPTH = 4;
  localparam int IDLE_TIMEOUT = 16;
  localparam int FRAME_W = 20;
  localparam int W = 8 * BPW;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [ADDR_W-1:0]  avm_address;
  logic               avm_read;
  logic [31:0]        avm_readdata;
  logic               avm_waitrequest;
  logic               i_clear;
  logic [FRAME_W-1:0] i_frame_words;
  logic [W-1:0]       o_data;
  logic               o_valid;
  logic               i_ready;
  logic [FRAME_W-1:0] o_word_idx;
  logic               o_frame_done;
  logic               o_drop;
  state_t             dbg_state;

  uart_word_loader #(
    .BYTES_PER_WORD (BPW),
    .ADDR_W         (ADDR_W),
    .RX_ADDR        (RX_ADDR),
    .STATUS_ADDR    (STATUS_ADDR),
    .RX_OK_BIT      (RX_OK_BIT),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .IDLE_TIMEOUT   (IDLE_TIMEOUT),
    .FRAME_W        (FRAME_W)
  ) dut (
    .avm_clk         (clk),
    .avm_rst_n       (rst_n),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .i_clear         (i_clear),
    .i_frame_words   (i_frame_words),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_word_idx      (o_word_idx),
    .o_frame_done    (o_frame_done),
    .o_drop          (o_drop),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  // ---------------- shared state ----------------
  int n_checks = 0;
  int n_pass = 0;

  logic [7:0]         rx_q[$];      // bytes the UART still holds
  logic [7:0]         partial[$];   // model: bytes of the word being assembled
  logic [W-1:0]       exp_q[$];     // model: words expected at the output
  logic [W-1:0]       m_word;
  logic [7:0]         m_byte;
  bit                 m_deliv;
  int                 idle = 0;
  int                 occ = 0;
  logic [FRAME_W-1:0] m_widx = '0;
  bit                 exp_drop = 0;
  bit                 exp_fd = 0;
  bit                 exp_push = 0;

  bit                 run = 0;
  bit                 in_xfer = 0;
  bit                 cancelled = 0;
  int                 stall_left = 0;
  int                 stall_cfg = 0;
  bit                 stall_rand = 0;
  int                 stall_max = 0;
  int                 gap_pct = 0;
  int                 status_reads = 0;

  bit                 last_read = 0;
  logic [ADDR_W-1:0]  last_addr = '0;
  int                 words_out = 0;
  int                 fd_count = 0;
  int                 drop_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- UART slave + reference model ----------------
  // Evaluated just after each falling edge: decides the slave response for the
  // coming rising edge and applies that edge's effect to the model.
  initial begin
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    forever begin
      @(negedge clk); #1;
      if (run) begin
        m_deliv = 0;
        m_byte = '0;
        if (avm_read) begin
          if (!in_xfer) begin
            in_xfer = 1;
            cancelled = 0;
            stall_left = stall_rand ? int'($urandom_range(0, stall_max)) : stall_cfg;
            if (avm_address == ADDR_W'(STATUS_ADDR)) status_reads++;
          end
          if (i_clear) cancelled = 1;
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avm_waitrequest = 1'b0;
            in_xfer = 0;
            avm_readdata = $urandom;
            if (avm_address == ADDR_W'(STATUS_ADDR)) begin
              avm_readdata[RX_OK_BIT] = (rx_q.size() != 0) && (int'($urandom_range(0, 99)) >= gap_pct);
            end else begin
              m_byte = (rx_q.size() != 0) ? rx_q.pop_front() : 8'($urandom);
              avm_readdata[7:0] = m_byte;
              m_deliv = !cancelled;
            end
          end
        end else begin
          avm_waitrequest = 1'b0;
          in_xfer = 0;
        end

        exp_drop = 0;
        exp_fd = 0;
        exp_push = 0;
        if (i_clear) begin
          partial.delete();
          exp_q.delete();
          occ = 0;
          m_widx = '0;
          idle = 0;
        end else if (m_deliv) begin
          partial.push_back(m_byte);
          idle = 0;
          if (partial.size() == BPW) begin
            m_word = '0;
            foreach (partial[k]) m_word = {m_word[W-9:0], partial[k]};
            exp_q.push_back(m_word);
            occ++;
            exp_push = 1;
            partial.delete();
            if (i_frame_words != '0 && m_widx == i_frame_words - 1'b1) begin
              m_widx = '0;
              exp_fd = 1;
            end else begin
              m_widx = m_widx + 1'b1;
            end
          end
        end else if (partial.size() != 0) begin
          idle++;
          if (idle >= IDLE_TIMEOUT) begin
            partial.delete();
            idle = 0;
            exp_drop = 1;
          end
        end else begin
          idle = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        check("drop_pulse", 32'(o_drop), 32'(exp_drop));
        check("frame_done", 32'(o_frame_done), 32'(exp_fd));
        check("word_idx", 32'(o_word_idx), 32'(m_widx));
        if (exp_push) check("valid_after_push", 32'(o_valid), 32'd1);
        if (last_read && avm_waitrequest) begin
          check("hold_read", 32'(avm_read), 32'd1);
          check("hold_addr", 32'(avm_address), 32'(last_addr));
        end
        if (last_read && !avm_waitrequest) check("read_gap", 32'(avm_read), 32'd0);
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got 0x%0h expected none at %0t", o_data, $time);
          end else begin
            check("word_data", 32'(o_data), 32'(exp_q.pop_front()));
          end
          occ--;
          words_out++;
        end
        if (o_frame_done) fd_count++;
        if (o_drop) drop_count++;
        last_read = avm_read;
        last_addr = avm_address;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((rx_q.size() != 0 || partial.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_occ(input string name, input int target, input int budget);
    int n = 0;
    while (occ != target && n < budget) begin
      step(1);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int base_w, base_fd, base_d, sr0, n;

  initial begin
    i_clear = 1'b0;
    i_frame_words = '0;
    i_ready = 1'b1;
    rst_n = 1'b0;
    step(3);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_addr", 32'(avm_address), 32'(STATUS_ADDR));
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_word_idx", 32'(o_word_idx), 32'd0);
    check("rst_frame_done", 32'(o_frame_done), 32'd0);
    check("rst_drop", 32'(o_drop), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_WAIT));
    rst_n = 1'b1;
    run = 1;
    step(2);

    // Basic word 0x123456, no stalls.
    base_w = words_out;
    rx_q.push_back(8'h12); rx_q.push_back(8'h34); rx_q.push_back(8'h56);
    wait_drain("t1_drain", 500);
    check("t1_words", 32'(words_out - base_w), 32'd1);

    // Same word with 5-cycle stalls on every read.
    stall_cfg = 5;
    base_w = words_out;
    rx_q.push_back(8'h12); rx_q.push_back(8'h34); rx_q.push_back(8'h56);
    wait_drain("t2_drain", 1000);
    check("t2_words", 32'(words_out - base_w), 32'd1);
    stall_cfg = 0;

    // Backpressure: 8 words into a 4-deep FIFO.
    i_ready = 1'b0;
    base_w = words_out;
    for (int i = 0; i < 8 * BPW; i++) rx_q.push_back(8'($urandom));
    wait_occ("t3_fill", FIFO_DEPTH, 1000);
    step(5);
    sr0 = status_reads;
    step(40);
    check("t3_no_poll", 32'(status_reads - sr0), 32'd0);
    check("t3_rx_left", 32'(rx_q.size()), 32'((8 - FIFO_DEPTH) * BPW));
    i_ready = 1'b1;
    wait_drain("t3_drain", 2000);
    check("t3_words", 32'(words_out - base_w), 32'd8);

    // Framing: 3 words per frame, 7 words.
    pulse_clear();
    i_frame_words = 20'd3;
    base_fd = fd_count;
    for (int i = 0; i < 7 * BPW; i++) rx_q.push_back(8'($urandom));
    wait_drain("t4_drain", 2000);
    step(2);
    check("t4_frame_done_count", 32'(fd_count - base_fd), 32'd2);
    check("t4_word_idx", 32'(o_word_idx), 32'd1);
    i_frame_words = '0;

    // Timeout: 2 bytes then silence drops the partial word.
    base_d = drop_count;
    base_w = words_out;
    rx_q.push_back(8'hA1); rx_q.push_back(8'hB2);
    wait_drain("t5_drain_drop", 300);
    step(2);
    check("t5_drop_count", 32'(drop_count - base_d), 32'd1);
    rx_q.push_back(8'hC3); rx_q.push_back(8'hD4); rx_q.push_back(8'hE5);
    wait_drain("t5_drain_word", 300);
    check("t5_words", 32'(words_out - base_w), 32'd1);

    // Clear during a stalled RX read with 2 words buffered.
    i_ready = 1'b0;
    base_w = words_out;
    for (int i = 0; i < 2 * BPW; i++) rx_q.push_back(8'($urandom));
    wait_occ("t6_fill", 2, 500);
    stall_cfg = 20;
    rx_q.push_back(8'h77);
    n = 0;
    while (!(in_xfer && avm_address == ADDR_W'(RX_ADDR) && stall_left > 2) && n < 500) begin
      step(1);
      n++;
    end
    check("t6_stall_seen", 32'(n < 500), 32'd1);
    pulse_clear();
    check("t6_valid_after_clear", 32'(o_valid), 32'd0);
    stall_cfg = 0;
    step(30);
    i_ready = 1'b1;
    rx_q.push_back(8'h9A); rx_q.push_back(8'hBC); rx_q.push_back(8'hDE);
    wait_drain("t6_drain", 500);
    check("t6_words", 32'(words_out - base_w), 32'd1);

    // Randomized traffic: stalls, status gaps, backpressure, sporadic clears.
    pulse_clear();
    i_frame_words = 20'd5;
    stall_rand = 1;
    stall_max = 3;
    gap_pct = 25;
    for (int c = 0; c < 800; c++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      i_clear = ($urandom_range(0, 199) == 0);
      if (rx_q.size() < 4) rx_q.push_back(8'($urandom));
      step(1);
    end
    i_clear = 1'b0;
    i_ready = 1'b1;
    wait_drain("t7_drain", 3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
